wb_trace_uart_tx: RTL
=====================

// Module: wb_trace_uart_tx
// PURPOSE
//  Debug-side transmitter for the pipeline's write-back bus. Captures each committed outMuxWb word
//  into a small FIFO and streams it off-chip on a UART line (8N1, LSB first) as 5-byte frames:
//  0xA5 header, then data[31:24], [23:16], [15:8], [7:0]. Host logger is the receiving end.
//  pipeEnable back-pressures the pipeline clock-enable so no word is lost in normal use.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    16   word capacity of capture FIFO; power of two, >= 2
//  HEADER        8'hA5  frame sync byte sent before each word
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   synchronous, active-high
//  inValid     in   1   write-back word valid this cycle (pipeline enabled and RegWrite)
//  inData      in   32  write-back value (outMuxWb)
//  txSerial    out  1   UART line, idle high
//  pipeEnable  out  1   1 = FIFO not full, pipeline may advance
//  busy        out  1   1 = FIFO non-empty or frame in flight
//  overflow    out  1   sticky: a word was offered while FIFO full and dropped
// BEHAVIOUR
//  Reset (sync, wins over everything): txSerial=1, pipeEnable=1, busy=0, overflow=0, FIFO emptied,
//   FSM=IDLE, all counters 0. Reset mid-frame aborts the frame; txSerial is 1 from the next cycle.
//  FIFO: registered count, width clog2(FIFO_DEPTH+1); rd/wr pointers wrap modulo FIFO_DEPTH.
//   Push when inValid && count<FIFO_DEPTH (full evaluated on pre-edge count). Pop only in IDLE.
//   Simultaneous push+pop: count unchanged, both take effect. inValid while full: word dropped
//   even if a pop happens the same cycle; overflow<=1 and stays set until reset.
//   pipeEnable = (count != FIFO_DEPTH), from registered count.
//  FSM states IDLE, START, DATA, STOP; baudCnt 0..CLKS_PER_BIT-1, bitIdx 0..7, byteIdx 0..4.
//   IDLE:  txSerial=1. If count!=0: pop word into frameWord, load shiftReg=HEADER, byteIdx=0, ->START.
//   START: txSerial=0 for CLKS_PER_BIT cycles, then bitIdx=0, ->DATA.
//   DATA:  txSerial=shiftReg[0]; after CLKS_PER_BIT cycles shift right; after bit 7 ->STOP.
//   STOP:  txSerial=1 for CLKS_PER_BIT cycles; then if byteIdx<4: byteIdx++, load next byte
//          (MSB-first byte order of frameWord), ->START; else ->IDLE.
//  txSerial is a registered output: it reflects the state entered on the same edge.
//  Latency: inValid at edge N -> FIFO at N+1 -> popped at N+2 with txSerial=0 from N+2 when idle.
//  Frame = 50*CLKS_PER_BIT cycles; back-to-back frames separated by exactly one extra high
//   cycle (IDLE pop cycle) after the final stop bit.
//  busy = (state!=IDLE) || (count!=0).
//  Bytes within a frame have no gap: next START follows STOP directly.
// TESTING  (bench: CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset held 3 cycles, idle inputs -> txSerial=1, pipeEnable=1, busy=0, overflow=0.
//  2 One inValid, inData=0x12345678 -> decoded line bytes A5,12,34,56,78; each bit 4 cycles,
//    start=0, stop=1; frame 200 cycles; busy falls the cycle after last stop bit.
//  3 Six consecutive inValid (words W0..W5), pipeEnable ignored -> pipeEnable=0 after 5th push,
//    overflow=1 after 6th; line carries W0..W4 in order, W5 never sent.
//  4 Two words pushed back-to-back -> second frame start bit begins 5 cycles after first
//    frame's final stop bit begins (4 stop + 1 idle).
//  5 reset asserted during data bit 3 of byte 2 (0x34) -> txSerial=1 next cycle, busy=0,
//    overflow cleared, no further line activity with inValid=0.
//  6 inValid while full in the same cycle as an IDLE pop -> count drops by 1, word dropped,
//    overflow=1.

Source files
------------

// File: rtl/wb_trace_uart_tx.sv
// Write-back trace transmitter: buffers committed words in a FIFO and streams each one
// over an 8N1 UART line as a 0xA5-prefixed 5-byte frame, most significant byte first.
module wb_trace_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    input  logic [31:0] inData,
    output logic        txSerial,
    output logic        pipeEnable,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txStateT;

    txStateT           state;
    logic [31:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic [BAUD_W-1:0] baudCnt;
    logic [2:0]        bitIdx;
    logic [2:0]        byteIdx;
    logic [7:0]        shiftReg;
    logic [31:0]       frameWord;
    logic              pushC;
    logic              popC;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room for a push.
    assign pushC      = inValid && (count != FULL);
    assign popC       = (state == IDLE) && (count != '0);
    assign pipeEnable = (count != FULL);
    assign busy       = (state != IDLE) || (count != '0);

    // Byte 1..4 of a frame is frameWord MSB-first; byte 0 is the header.
    function automatic logic [7:0] pickByte(input logic [31:0] word, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // Capture storage needs no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (pushC) begin
            fifoMem[wrPtr] <= inData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            txSerial  <= 1'b1;
            overflow  <= 1'b0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            baudCnt   <= '0;
            bitIdx    <= '0;
            byteIdx   <= '0;
            shiftReg  <= '0;
            frameWord <= '0;
        end else begin
            if (pushC) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popC) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({pushC, popC})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (inValid && (count == FULL)) begin
                overflow <= 1'b1;
            end

            // Line FSM; txSerial always takes the level of the state being entered.
            case (state)
                IDLE: begin
                    txSerial <= 1'b1;
                    baudCnt  <= '0;
                    if (popC) begin
                        frameWord <= fifoMem[rdPtr];
                        shiftReg  <= HEADER;
                        byteIdx   <= '0;
                        state     <= START;
                        txSerial  <= 1'b0;
                    end
                end
                START: begin
                    if (baudCnt == BAUD_LAST) begin
                        baudCnt  <= '0;
                        bitIdx   <= '0;
                        state    <= DATA;
                        txSerial <= shiftReg[0];
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baudCnt == BAUD_LAST) begin
                        baudCnt  <= '0;
                        shiftReg <= shiftReg >> 1;
                        if (bitIdx == 3'd7) begin
                            state    <= STOP;
                            txSerial <= 1'b1;
                        end else begin
                            bitIdx   <= bitIdx + 3'd1;
                            txSerial <= shiftReg[1];
                        end
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baudCnt == BAUD_LAST) begin
                        baudCnt <= '0;
                        if (byteIdx < 3'd4) begin
                            byteIdx  <= byteIdx + 3'd1;
                            shiftReg <= pickByte(frameWord, byteIdx + 3'd1);
                            state    <= START;
                            txSerial <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            txSerial <= 1'b1;
                        end
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    txSerial <= 1'b1;
                end
            endcase
        end
    end

endmodule
